spi_master: RTL and testbench

SPI bus master (mode 0: CPOL=0, CPHA=0, MSB first) that generates SCK, SS and MOSI and samples MISO for the FPGA-side SPI slave and other mode-0 peripherals. Words enter on a valid/ready transmit stream and leave on a one-cycle-strobe receive stream. Consecutive words are chained inside one SS-low transaction until a word flagged `tx_last` completes, or until no next word is offered at the word boundary.

---
 rtl/spi_master_if.sv | 32 +++
 rtl/spi_master.sv | 197 +++++++++++++++++++
 tb/tb_spi_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// ---------------------------------------------------------------------------
// spi_master_if
//
// Word-level streams between the SPI master and the logic that feeds it.
//   tx_data/tx_last/tx_valid : word to transmit (valid/ready handshake)
//   tx_ready                 : the master accepts the word on this edge
//   rx_data/rx_valid         : received word, rx_valid is a one-cycle strobe
//
// Modports:
//   master : upstream user that offers tx words and consumes rx words
//   slave  : the spi_master block itself
// ---------------------------------------------------------------------------
interface spi_master_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_last;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;

    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//
// Mode-0 SPI master (CPOL=0, CPHA=0, MSB first). Words arrive on a
// valid/ready stream and received words leave as a one-cycle strobe.
// Consecutive words are chained under one SS-low transaction until a word
// flagged tx_last completes or no next word is offered at the word boundary.
//
// Ports:
//   clk, reset : single clock, synchronous active-high reset
//   bus        : spi_master_if.slave (tx stream in, rx stream out)
//   busy       : high whenever the FSM is not IDLE
//   SCK        : serial clock, idles low
//   MOSI       : master data out
//   MISO       : slave data in, asynchronous to clk
//   SS         : active-low slave select
//
// Parameters:
//   CLK_DIV : clk cycles per SCK half-period (>= 2)
//   DATA_W  : bits per word (>= 2)
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    spi_master_if.slave bus,
    output logic        busy,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SS
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              last_q, last_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic              rx_valid_q, rx_valid_d;
    logic              busy_q, busy_d;
    logic              miso_meta_q, miso_s_q;

    logic div_end;
    logic last_bit;
    logic tx_ready_c;
    logic accept;

    assign div_end  = (div_cnt_q == DIV_LAST);
    assign last_bit = (bit_cnt_q == BIT_LAST);

    // Ready in IDLE, and in the very last cycle of a word when the current
    // word did not end the transaction, so the next word can chain in.
    assign tx_ready_c = !reset &&
                        ((state_q == IDLE) ||
                         (state_q == LOW && div_end && last_bit && !last_q));
    assign accept     = tx_ready_c && bus.tx_valid;

    assign bus.tx_ready = tx_ready_c;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign busy         = busy_q;
    assign SCK          = sck_q;
    assign MOSI         = mosi_q;
    assign SS           = ss_q;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        rx_valid_d = 1'b0;

        // Every timed state exits exactly at div_end, so wrapping the
        // counter there is the same as clearing it on each state change.
        if (state_q != IDLE) begin
            div_cnt_d = div_end ? '0 : div_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sh_d   = bus.tx_data;
                    last_d    = bus.tx_last;
                    mosi_d    = bus.tx_data[DATA_W-1];
                    ss_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (div_end) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (div_end) begin
                    // Sample as late as possible in the high phase.
                    rx_sh_d = {rx_sh_q[DATA_W-2:0], miso_s_q};
                    sck_d   = 1'b0;
                    state_d = LOW;
                    if (!last_bit) begin
                        tx_sh_d = tx_sh_q << 1;
                        mosi_d  = tx_sh_q[DATA_W-2];
                    end
                end
            end
            LOW: begin
                if (div_end) begin
                    if (!last_bit) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sck_d     = 1'b1;
                        state_d   = HIGH;
                    end else begin
                        rx_data_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                        if (accept) begin
                            tx_sh_d   = bus.tx_data;
                            last_d    = bus.tx_last;
                            mosi_d    = bus.tx_data[DATA_W-1];
                            bit_cnt_d = '0;
                            state_d   = SETUP;
                        end else begin
                            ss_d    = 1'b1;
                            mosi_d  = 1'b0;
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (div_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    // Shift registers are fully rewritten by every word, and MISO is
    // asynchronous, so none of these need a reset.
    always_ff @(posedge clk) begin
        miso_meta_q <= MISO;
        miso_s_q    <= miso_meta_q;
        tx_sh_q     <= tx_sh_d;
        rx_sh_q     <= rx_sh_d;
    end
endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
//
// Two instances: dut0 with CLK_DIV=4/DATA_W=8, dut1 with CLK_DIV=2/DATA_W=16.
// Stimulus pushes the expected received word and its due cycle into a
// queue; a monitor pops and compares whenever rx_valid is seen.
// ---------------------------------------------------------------------------
module tb_spi_master;
    localparam int LAT0  = 68;   // (2*8+1)*4
    localparam int LAT1  = 66;   // (2*16+1)*2
    localparam int LIMIT = 2000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic sck0, mosi0, ss0, busy0, miso0;
    logic sck1, mosi1, ss1, busy1, miso1;
    int   miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low

    assign miso0 = (miso_mode == 0) ? mosi0 : (miso_mode == 1);
    assign miso1 = mosi1;

    spi_master_if #(.DATA_W(8))  if0 ();
    spi_master_if #(.DATA_W(16)) if1 ();

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut0 (
        .clk(clk), .reset(reset), .bus(if0), .busy(busy0),
        .SCK(sck0), .MOSI(mosi0), .MISO(miso0), .SS(ss0)
    );

    spi_master #(.CLK_DIV(2), .DATA_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(if1), .busy(busy1),
        .SCK(sck1), .MOSI(mosi1), .MISO(miso1), .SS(ss1)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_pass = 0, n_total = 0;     // main-thread checks
    int sb_pass = 0, sb_total = 0;   // scoreboard checks

    int rise0 = 0, rise1 = 0, per0 = 0, per1 = 0;
    int last_rise0 = 0, last_rise1 = 0, ss_rise0 = 0;
    int rxv0 = 0, rxv1 = 0, rxv_cyc0 = 0;
    logic ss_at_rxv0 = 1'b0;
    logic [31:0] cap0 = '0, cap1 = '0;
    logic prev_sck0 = 1'b0, prev_sck1 = 1'b0, prev_ss0 = 1'b1;

    task automatic sb_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        sb_total++;
        if (act === exp) sb_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: got no event, required one within %0d cycles", name, LIMIT);
    endtask

    // Monitor: SCK edge capture and rx scoreboard, sampled on the falling clk edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sck0 && !prev_sck0 && !ss0) begin
                rise0++;
                cap0 = {cap0[30:0], mosi0};
                per0 = cyc - last_rise0;
                last_rise0 = cyc;
            end
            if (sck1 && !prev_sck1 && !ss1) begin
                rise1++;
                cap1 = {cap1[30:0], mosi1};
                per1 = cyc - last_rise1;
                last_rise1 = cyc;
            end
            if (ss0 && !prev_ss0) ss_rise0++;
            prev_sck0 = sck0;
            prev_sck1 = sck1;
            prev_ss0  = ss0;

            if (if0.rx_valid) begin
                rxv0++;
                rxv_cyc0   = cyc;
                ss_at_rxv0 = ss0;
                if (sb0.size() == 0) begin
                    sb_total++;
                    $display("FAIL rx0_unexpected: got rx_valid with 0x%0h, required none", if0.rx_data);
                end else begin
                    e = sb0.pop_front();
                    sb_chk("rx0_data", 32'(if0.rx_data), e.data);
                    sb_chk("rx0_latency", cyc, e.due);
                end
            end
            if (if1.rx_valid) begin
                rxv1++;
                if (sb1.size() == 0) begin
                    sb_total++;
                    $display("FAIL rx1_unexpected: got rx_valid with 0x%0h, required none", if1.rx_data);
                end else begin
                    e = sb1.pop_front();
                    sb_chk("rx1_data", 32'(if1.rx_data), e.data);
                    sb_chk("rx1_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a word to dut0; returns one cycle after it was accepted.
    task automatic send0(input logic [7:0] d, input logic l, input bit keep,
                         input logic [7:0] exp_rx, input bit push);
        int n = 0;
        exp_t e;
        if0.tx_data  = d;
        if0.tx_last  = l;
        if0.tx_valid = 1'b1;
        while (!if0.tx_ready && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            timeout("send0_accept");
            if0.tx_valid = 1'b0;
            return;
        end
        if (push) begin
            e.data = 32'(exp_rx);
            e.due  = cyc + 1 + LAT0;
            sb0.push_back(e);
        end
        tick();
        if (!keep) if0.tx_valid = 1'b0;
    endtask

    task automatic send1(input logic [15:0] d, input logic l,
                         input logic [15:0] exp_rx);
        int n = 0;
        exp_t e;
        if1.tx_data  = d;
        if1.tx_last  = l;
        if1.tx_valid = 1'b1;
        while (!if1.tx_ready && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            timeout("send1_accept");
            if1.tx_valid = 1'b0;
            return;
        end
        e.data = 32'(exp_rx);
        e.due  = cyc + 1 + LAT1;
        sb1.push_back(e);
        tick();
        if1.tx_valid = 1'b0;
    endtask

    task automatic wait_rx0(input int target);
        int n = 0;
        while (rxv0 < target && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) timeout("wait_rx0");
    endtask

    task automatic wait_idle0();
        int n = 0;
        while ((busy0 || sb0.size() != 0) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) timeout("wait_idle0");
    endtask

    task automatic wait_idle1();
        int n = 0;
        while ((busy1 || sb1.size() != 0) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) timeout("wait_idle1");
    endtask

    initial begin
        int base, ssb, rxb, t0, n;

        if0.tx_valid = 1'b0; if0.tx_data = '0; if0.tx_last = 1'b0;
        if1.tx_valid = 1'b0; if1.tx_data = '0; if1.tx_last = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_ss", 32'(ss0), 1);
        chk("rst_sck", 32'(sck0), 0);
        chk("rst_mosi", 32'(mosi0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_rx_valid", 32'(if0.rx_valid), 0);
        chk("rst_rx_data", 32'(if0.rx_data), 0);
        chk("rst_tx_ready", 32'(if0.tx_ready), 0);
        reset = 1'b0;
        tick();
        chk("idle_tx_ready", 32'(if0.tx_ready), 1);

        // Single word 0xA5, loopback
        base = rise0;
        rxb  = rxv0;
        send0(8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
        wait_rx0(rxb + 1);
        chk("a5_ss_at_rxv", 32'(ss_at_rxv0), 1);
        t0 = rxv_cyc0;
        n  = 0;
        while (!if0.tx_ready && n < 100) begin
            tick();
            n++;
        end
        chk("a5_ready_gap", cyc - t0, 4);
        wait_idle0();
        chk("a5_rises", rise0 - base, 8);
        chk("a5_mosi_bits", 32'(cap0[7:0]), 32'hA5);
        chk("a5_sck_period", per0, 8);

        // Chained 0x3C then 0xC3 with tx_valid held
        base = rise0;
        ssb  = ss_rise0;
        rxb  = rxv0;
        send0(8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1);
        send0(8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1);
        chk("chain_first_rx", rxv0 - rxb, 1);
        t0 = rxv_cyc0;
        wait_rx0(rxb + 2);
        chk("chain_rx_spacing", rxv_cyc0 - t0, 68);
        wait_idle0();
        chk("chain_rises", rise0 - base, 16);
        chk("chain_mosi_bits", 32'(cap0[15:0]), 32'h3CC3);
        chk("chain_ss_rises", ss_rise0 - ssb, 1);

        // 0x12 with tx_last=0 and no follow-on word
        rxb = rxv0;
        send0(8'h12, 1'b0, 1'b0, 8'h12, 1'b1);
        wait_rx0(rxb + 1);
        chk("drop_ss_at_rxv", 32'(ss_at_rxv0), 1);
        wait_idle0();
        chk("drop_busy", 32'(busy0), 0);
        chk("drop_ss", 32'(ss0), 1);
        chk("drop_tx_ready", 32'(if0.tx_ready), 1);

        // MISO tied high, then tied low
        miso_mode = 1;
        send0(8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);
        wait_idle0();
        miso_mode = 2;
        send0(8'hFF, 1'b1, 1'b0, 8'h00, 1'b1);
        wait_idle0();
        miso_mode = 0;

        // Reset after the third rising edge of a word
        base = rise0;
        rxb  = rxv0;
        send0(8'hE7, 1'b1, 1'b0, 8'h00, 1'b0);
        n = 0;
        while (rise0 - base < 3 && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) timeout("mid_rst_rises");
        chk("mid_rst_mosi_before", 32'(mosi0), 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_ss", 32'(ss0), 1);
        chk("mid_rst_sck", 32'(sck0), 0);
        chk("mid_rst_mosi", 32'(mosi0), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_tx_ready", 32'(if0.tx_ready), 0);
        reset = 1'b0;
        repeat (100) tick();
        chk("mid_rst_no_rxv", rxv0 - rxb, 0);
        send0(8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1);
        wait_idle0();
        chk("post_rst_mosi_bits", 32'(cap0[7:0]), 32'h5A);

        // CLK_DIV=2, DATA_W=16 instance
        base = rise1;
        send1(16'hBEEF, 1'b1, 16'hBEEF);
        wait_idle1();
        chk("w16_rises", rise1 - base, 16);
        chk("w16_mosi_bits", 32'(cap1[15:0]), 32'hBEEF);
        chk("w16_sck_period", per1, 4);
        chk("w16_rx_count", rxv1, 1);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass + sb_pass, n_total + sb_total);
        $finish;
    end
endmodule
